// File: rtl/ibex_icache_fetch_pkg.sv
// Shared types and constants for the icache line fetcher.
//   fetch_state_e : fetcher FSM states (also exported on the debug port)
//   BUS_W         : instruction bus data width in bits
//   BUS_BYTES     : bytes per bus word
package ibex_icache_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        ABORT = 2'd3
    } fetch_state_e;

    localparam int BUS_W     = 32;
    localparam int BUS_BYTES = 4;

endpackage

// File: rtl/ibex_icache_line_fetcher.sv
// Line fetcher: the initiator side of the icache instruction-memory bus.
// Accepts one line-fill command, issues one request per word while keeping at
// most NumOutstanding granted-but-unanswered requests, collects the in-order
// responses into a line buffer and pulses fill_done_o with an error flag.
//
// Handshakes:
//   fill command : accepted in a cycle where fill_req_i && fill_ready_o.
//   bus request  : mem_req_o/mem_addr_o are raised from a register and held
//                  unchanged until mem_gnt_i (transfer) or mem_pmp_err_i
//                  (request ends without transfer); never retracted.
//   bus response : mem_rvalid_i returns one word per earlier grant, in order;
//                  mem_rdata_i/mem_err_i are only meaningful with it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fill_req_i/addr_i   fill command and line address (offset bits ignored)
//   fill_ready_o        fetcher idle, command will be accepted
//   fill_abort_i        cancel the running fill, no completion is reported
//   fill_done_o         one-cycle completion pulse
//   fill_err_o          any word faulted (valid with fill_done_o)
//   fill_data_o         line buffer, word 0 in the LSBs
//   mem_*               instruction bus (req/gnt/addr, pmp_err, rvalid/rdata/err)
//   dbg_state_o         current FSM state
module ibex_icache_line_fetcher
    import ibex_icache_fetch_pkg::*;
#(
    parameter int LineWords      = 4,
    parameter int NumOutstanding = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fill_req_i,
    input  logic [31:0]                  fill_addr_i,
    output logic                         fill_ready_o,
    input  logic                         fill_abort_i,
    output logic                         fill_done_o,
    output logic                         fill_err_o,
    output logic [BUS_W*LineWords-1:0]   fill_data_o,
    output logic                         mem_req_o,
    output logic [31:0]                  mem_addr_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_pmp_err_i,
    input  logic                         mem_rvalid_i,
    input  logic [BUS_W-1:0]             mem_rdata_i,
    input  logic                         mem_err_i,
    output fetch_state_e                 dbg_state_o
);

    localparam int IdxW = $clog2(LineWords) + 1;
    localparam int CntW = $clog2(NumOutstanding + 1);
    localparam int OffW = $clog2(LineWords * BUS_BYTES);

    fetch_state_e     r_state, w_state_next;
    logic [31:0]      r_base;
    logic [IdxW-1:0]  r_issue_idx, r_rsp_idx, w_issue_idx_next;
    logic [CntW-1:0]  r_outstanding, w_out_next;
    logic             r_err, r_req, r_done, r_out_en;
    logic [BUS_W-1:0] r_line [LineWords];

    logic w_ready, w_accept, w_grant, w_pmp, w_rsp, w_rsp_err;
    logic w_req_hold, w_room, w_stop, w_req_next, w_quiet, w_done_next;
    logic w_unused_addr;

    // Offset bits inside the line are intentionally ignored.
    assign w_unused_addr = ^fill_addr_i[OffW-1:0];

    // r_out_en keeps fill_ready_o low while reset is applied and for the first
    // cycle after release, so every output reads 0 during reset.
    assign w_ready    = r_out_en && (r_state == IDLE);
    assign w_accept   = fill_req_i && w_ready;
    // pmp_err ends the request without a transfer, even if gnt is also high.
    assign w_grant    = r_req && mem_gnt_i && !mem_pmp_err_i;
    assign w_pmp      = r_req && mem_pmp_err_i;
    assign w_rsp      = mem_rvalid_i && (r_outstanding != '0);
    assign w_rsp_err  = w_rsp && mem_err_i;
    assign w_req_hold = r_req && !mem_gnt_i && !mem_pmp_err_i;

    assign w_issue_idx_next = r_issue_idx + (w_grant ? IdxW'(1) : '0);

    always_comb begin
        w_out_next = r_outstanding;
        case ({w_grant, w_rsp})
            2'b10:   w_out_next = r_outstanding + CntW'(1);
            2'b01:   w_out_next = r_outstanding - CntW'(1);
            default: w_out_next = r_outstanding;
        endcase
    end

    assign w_room = (w_issue_idx_next < IdxW'(LineWords)) &&
                    (w_out_next < CntW'(NumOutstanding));
    assign w_stop = w_pmp || w_rsp_err || (w_issue_idx_next == IdxW'(LineWords));

    // Next request: a raised request is always held until it ends; a new one
    // is only raised while issuing normally and there is room for it.
    always_comb begin
        w_req_next = w_req_hold;
        if (w_accept) begin
            w_req_next = 1'b1;
        end else if (r_state == ISSUE && !fill_abort_i && !w_stop) begin
            w_req_next = w_req_hold || w_room;
        end
    end

    // Nothing left on the bus after this edge.
    assign w_quiet = (w_out_next == '0) && !w_req_next;

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state. Completion is decided on the edge where the bus goes
    // quiet, so fill_done_o rises in the first cycle with nothing outstanding.
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = ISSUE;
            end
            ISSUE: begin
                if (fill_abort_i) begin
                    w_state_next = w_quiet ? IDLE : ABORT;
                end else if (w_stop) begin
                    w_state_next = w_quiet ? IDLE : DRAIN;
                    w_done_next  = w_quiet;
                end
            end
            DRAIN: begin
                if (fill_abort_i) begin
                    w_state_next = w_quiet ? IDLE : ABORT;
                end else if (w_quiet) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            ABORT: begin
                if (w_quiet) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base        <= '0;
            r_issue_idx   <= '0;
            r_rsp_idx     <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
            r_req         <= 1'b0;
            r_done        <= 1'b0;
            r_out_en      <= 1'b0;
            for (int i = 0; i < LineWords; i++) r_line[i] <= '0;
        end else begin
            r_out_en      <= 1'b1;
            r_req         <= w_req_next;
            r_done        <= w_done_next;
            r_outstanding <= w_out_next;
            if (w_accept) begin
                r_base      <= {fill_addr_i[31:OffW], {OffW{1'b0}}};
                r_issue_idx <= '0;
                r_rsp_idx   <= '0;
                r_err       <= 1'b0;
                // Words that are never fetched read back as 0.
                for (int i = 0; i < LineWords; i++) r_line[i] <= '0;
            end else begin
                r_issue_idx <= w_issue_idx_next;
                if (w_rsp) r_rsp_idx <= r_rsp_idx + IdxW'(1);
                if (w_pmp || w_rsp_err) r_err <= 1'b1;
                // Responses drained during an abort are discarded.
                if (w_rsp && r_state != ABORT && r_rsp_idx < IdxW'(LineWords)) begin
                    r_line[r_rsp_idx[IdxW-2:0]] <= mem_rdata_i;
                end
            end
        end
    end

    // FSM: outputs.
    always_comb begin
        fill_ready_o = w_ready;
        fill_done_o  = r_done;
        fill_err_o   = r_done && r_err;
        mem_req_o    = r_req;
        mem_addr_o   = '0;
        if (r_req) mem_addr_o = r_base + (32'(r_issue_idx) << 2);
        fill_data_o  = '0;
        for (int i = 0; i < LineWords; i++) fill_data_o[i*BUS_W +: BUS_W] = r_line[i];
        dbg_state_o  = r_state;
    end

    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rvalid_i |-> (r_outstanding != '0));
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_req && !mem_gnt_i && !mem_pmp_err_i) |=> (r_req && $stable(mem_addr_o)));
    a_issue_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_issue_idx <= IdxW'(LineWords));

endmodule

// File: tb/tb_ibex_icache_line_fetcher.sv
module tb_ibex_icache_line_fetcher;
  import ibex_icache_fetch_pkg::*;

  localparam int LW = 4;
  localparam int NO = 2;
  localparam int DW = 32 * LW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          fill_req_i = 1'b0;
  logic [31:0]   fill_addr_i = '0;
  logic          fill_ready_o;
  logic          fill_abort_i = 1'b0;
  logic          fill_done_o;
  logic          fill_err_o;
  logic [DW-1:0] fill_data_o;
  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_pmp_err_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [31:0]   mem_rdata_i = '0;
  logic          mem_err_i = 1'b0;
  fetch_state_e  dbg_state_o;

  ibex_icache_line_fetcher #(.LineWords(LW), .NumOutstanding(NO)) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_req_i(fill_req_i), .fill_addr_i(fill_addr_i), .fill_ready_o(fill_ready_o),
    .fill_abort_i(fill_abort_i), .fill_done_o(fill_done_o), .fill_err_o(fill_err_o),
    .fill_data_o(fill_data_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_pmp_err_i(mem_pmp_err_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];  // expected request addresses of the running fill

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;
  rsp_t rq[$];            // granted words waiting for their response
  int last_due = 0;

  // bus responder settings
  int gnt_pct = 100, dly_min = 1, dly_max = 1, pmp_word = -1, err_word = -1, hold_left = 0;
  bit fixed_data = 1'b0;

  // fill model
  bit          busy = 1'b0, aborted = 1'b0, stopped = 1'b0, exp_err = 1'b0;
  logic [31:0] base = '0;
  int          n_granted = 0, rsp_count = 0;
  logic [31:0] exp_line [LW];
  int          exp_done_cyc = -1, accept_cyc = 0, done_cyc = 0, done_cnt = 0, max_out = 0;
  logic        done_err = 1'b0;
  bit          pend_prev = 1'b0;
  logic [31:0] addr_prev = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pack_line();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < LW; i++) v[i*32 +: 32] = exp_line[i];
    return v;
  endfunction

  task automatic set_bus(input int gp, input int dmin, input int dmax, input int pw,
                         input int ew, input int hold, input bit fixed);
    gnt_pct = gp; dly_min = dmin; dly_max = dmax; pmp_word = pw; err_word = ew;
    hold_left = hold; fixed_data = fixed; max_out = 0;
  endtask

  // ---------------- driver: one bus cycle ----------------
  // Drives the fill inputs and the bus responder for one cycle, checks the
  // DUT outputs of that cycle against the model, then advances the model.
  task automatic step(input logic freq, input logic [31:0] faddr, input logic fabort);
    logic req, gnt, pmp, rv, pend, allowed;
    logic [31:0] addr;
    rsp_t r;
    int dly;
    @(negedge clk);
    cyc++;
    fill_req_i = freq; fill_addr_i = faddr; fill_abort_i = fabort;
    req = mem_req_o; addr = mem_addr_o;

    chk("ready", fill_ready_o, !busy);
    chk("done", fill_done_o, cyc == exp_done_cyc);
    if (fill_done_o) begin
      done_cnt++; done_cyc = cyc; done_err = fill_err_o;
      chk("line_data", fill_data_o, pack_line());
      chk("line_err", fill_err_o, exp_err);
    end
    allowed = busy && !stopped && !aborted && n_granted < LW && rq.size() < NO;
    if (pend_prev) begin
      chk("req_hold", req, 1'b1);
      chk("addr_hold", addr, addr_prev);
    end else if (!allowed) begin
      chk("req_unexpected", req, 1'b0);
    end
    if (req && exp_q.size() > 0) chk("addr", addr, exp_q[0]);

    // responder
    gnt = 1'b0; pmp = 1'b0; rv = 1'b0;
    if (req && hold_left > 0) hold_left--;
    else if (req) gnt = ($urandom_range(99, 0) < gnt_pct);
    else gnt = $urandom_range(1, 0);  // stray grant without a request
    if (req && busy && !aborted && n_granted == pmp_word) pmp = 1'b1;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      rv = 1'b1; mem_rdata_i = rq[0].data; mem_err_i = rq[0].err;
    end else begin
      mem_rdata_i = $urandom; mem_err_i = $urandom_range(1, 0);
    end
    mem_gnt_i = gnt; mem_pmp_err_i = pmp; mem_rvalid_i = rv;

    // model update for this cycle
    if (fabort && busy) aborted = 1'b1;
    if (freq && !busy) begin
      busy = 1'b1; aborted = 1'b0; stopped = 1'b0; exp_err = 1'b0;
      base = faddr & ~32'(LW * 4 - 1);
      n_granted = 0; rsp_count = 0; accept_cyc = cyc;
      for (int i = 0; i < LW; i++) exp_line[i] = '0;
      exp_q.delete();
      for (int i = 0; i < LW; i++) exp_q.push_back(base + 32'(4 * i));
    end
    if (rv) begin
      r = rq.pop_front();
      if (busy && !aborted) begin
        if (rsp_count < LW) exp_line[rsp_count] = r.data;
        if (r.err) begin exp_err = 1'b1; stopped = 1'b1; end
      end
      rsp_count++;
    end
    if (req && pmp && !aborted) begin exp_err = 1'b1; stopped = 1'b1; end
    if (req && gnt && !pmp) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      dly = $urandom_range(dly_max, dly_min);
      r.due  = (cyc + dly > last_due) ? cyc + dly : last_due + 1;
      last_due = r.due;
      r.data = fixed_data ? 32'hA0 + 32'(n_granted) : $urandom;
      r.err  = (n_granted == err_word);
      rq.push_back(r);
      n_granted++;
    end
    if (rq.size() > max_out) max_out = rq.size();
    pend = req && !gnt && !pmp;
    pend_prev = pend; addr_prev = addr;
    if (busy && rq.size() == 0 && !pend && (aborted || stopped || n_granted == LW)) begin
      busy = 1'b0;
      if (!aborted) exp_done_cyc = cyc + 1;
    end
  endtask

  task automatic run_fill(input logic [31:0] a, input int abort_at);
    step(1'b1, a, 1'b0);
    for (int k = 0; k < 300 && (busy || cyc < exp_done_cyc); k++) step(1'b0, '0, k == abort_at);
    if (busy) chk("fill_timeout", busy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, mem_req_o, 1'b0);
    chk({tag, "_addr"}, mem_addr_o, '0);
    chk({tag, "_done"}, fill_done_o, 1'b0);
    chk({tag, "_err"}, fill_err_o, 1'b0);
    chk({tag, "_data"}, fill_data_o, '0);
    chk({tag, "_ready"}, fill_ready_o, 1'b0);
    chk({tag, "_state"}, dbg_state_o, IDLE);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    busy = 1'b0; aborted = 1'b0; stopped = 1'b0; pend_prev = 1'b0;
    rq.delete(); exp_q.delete(); exp_done_cyc = -1;
    fill_req_i = 1'b0; fill_abort_i = 1'b0;
    mem_gnt_i = 1'b0; mem_pmp_err_i = 1'b0; mem_rvalid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0);
    chk("ready_after_rst", fill_ready_o, 1'b1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- tests ----------------
  initial begin
    int snap;
    logic [DW-1:0] line_a;
    line_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    #2;
    chk_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0);

    // 1: clean fill, one-cycle response latency
    set_bus(100, 1, 1, -1, -1, 0, 1'b1);
    run_fill(32'h0000_1000, -1);
    chk("t1_latency", 32'(done_cyc - accept_cyc), 32'd6);
    chk("t1_err", done_err, 1'b0);
    step(1'b0, '0, 1'b1);  // abort while idle is ignored
    step(1'b0, '0, 1'b0);
    chk("t1_data_held", fill_data_o, line_a);

    // 2: first grant withheld, slow responses
    set_bus(100, 5, 5, -1, -1, 3, 1'b0);
    run_fill(32'h0000_100C, -1);
    chk("t2_peak_out", 32'(max_out), 32'(NO));
    chk("t2_granted", 32'(n_granted), 32'(LW));

    // 3: pmp fault on word 2
    set_bus(100, 1, 3, 2, -1, 0, 1'b0);
    run_fill(32'h0000_2008, -1);
    chk("t3_granted", 32'(n_granted), 32'd2);
    chk("t3_err", done_err, 1'b1);
    chk("t3_hi_zero", fill_data_o[DW-1:64], '0);

    // 4: bus error on word 1
    set_bus(100, 4, 4, -1, 1, 0, 1'b0);
    run_fill(32'h0000_2400, -1);
    chk("t4_granted", 32'(n_granted), 32'd3);
    chk("t4_err", done_err, 1'b1);

    // 5: abort with two outstanding, then a clean fill
    set_bus(100, 5, 5, -1, -1, 0, 1'b0);
    snap = done_cnt;
    step(1'b1, 32'h0000_2800, 1'b0);
    for (int k = 0; k < 20 && rq.size() < NO; k++) step(1'b0, '0, 1'b0);
    chk("t5_out_before_abort", 32'(rq.size()), 32'(NO));
    step(1'b0, '0, 1'b1);
    for (int k = 0; k < 40 && busy; k++) step(1'b0, '0, 1'b0);
    chk("t5_drained", busy, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    chk("t5_no_done", 32'(done_cnt), 32'(snap));
    set_bus(100, 1, 2, -1, -1, 0, 1'b1);
    run_fill(32'h0000_3000, -1);
    chk("t5_next_fill", fill_data_o, line_a);

    // 6: grant and response in the same cycle, then reset mid-fill
    set_bus(100, 1, 1, -1, -1, 0, 1'b0);
    run_fill(32'h0000_3400, -1);
    chk("t6_peak_out", 32'(max_out), 32'd1);
    step(1'b1, 32'h0000_3800, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    reset_mid();

    // 7: randomized fills
    for (int n = 0; n < 30; n++) begin
      int dmin, pw, ew, ab;
      dmin = $urandom_range(3, 1);
      pw = ($urandom_range(3, 0) == 0) ? $urandom_range(LW - 1, 0) : -1;
      ew = ($urandom_range(3, 0) == 0) ? $urandom_range(LW - 1, 0) : -1;
      ab = ($urandom_range(4, 0) == 0) ? $urandom_range(8, 0) : -1;
      set_bus($urandom_range(100, 30), dmin, $urandom_range(6, dmin), pw, ew, 0, 1'b0);
      run_fill($urandom, ab);
      repeat ($urandom_range(2, 0)) step(1'b0, '0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
